// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, next-PC selects and instruction field positions for the fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int JMP_MSB = 25;
    localparam int JMP_LSB = 0;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    function automatic logic [31:0] sext_imm(input logic [31:0] ir);
        return {{16{ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC select: sequential, PC-relative branch or absolute jump
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc_plus1_i,
    input  logic [31:0] ir_i,
    input  logic [1:0]  pc_src_i,
    input  logic        br_taken_i,
    output logic [31:0] next_pc_o
);

    always_comb begin
        next_pc_o = pc_plus1_i;
        case (pc_src_i)
            PC_BR: begin
                if (br_taken_i) begin
                    next_pc_o = pc_plus1_i + sext_imm(ir_i);
                end
            end
            PC_JMP: next_pc_o = {pc_plus1_i[OPC_MSB:OPC_LSB], ir_i[JMP_MSB:JMP_LSB]};
            default: next_pc_o = pc_plus1_i;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, IR, IDLE/FETCH/HOLD handshake; FETCH_PERF_EN adds a fetch counter
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [31:0] pc_out,
    input  logic [31:0] imem_instr,
    output logic [31:0] ir_out,
    output logic        ir_valid,
    output logic [31:0] pc_plus1,
    input  logic        pc_advance,
    input  logic [1:0]  pc_src,
    input  logic        br_taken,
    output logic        adv_err,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  pc_plus1_q, pc_plus1_d;
    logic         adv_err_q, adv_err_d;
    logic [31:0]  next_pc;
    logic         load_ir;

    next_pc_calc u_next_pc (
        .pc_plus1_i (pc_plus1_q),
        .ir_i       (ir_q),
        .pc_src_i   (pc_src),
        .br_taken_i (br_taken),
        .next_pc_o  (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        pc_plus1_d = pc_plus1_q;
        adv_err_d  = adv_err_q;
        load_ir    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pc_advance) adv_err_d = 1'b1;
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // A dropped run does not abort: the word is already on the bus.
                if (pc_advance) adv_err_d = 1'b1;
                load_ir    = 1'b1;
                ir_d       = imem_instr;
                pc_plus1_d = pc_q + 32'd1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (pc_advance) begin
                    pc_d    = next_pc;
                    state_d = run ? ST_FETCH : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 32'd0;
            pc_plus1_q <= 32'd0;
            adv_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            pc_plus1_q <= pc_plus1_d;
            adv_err_q  <= adv_err_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (load_ir) fetch_count_d = fetch_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    logic unused_load_ir;
    assign unused_load_ir = load_ir;
    assign fetch_count    = 32'd0;
`endif

    assign pc_out   = pc_q;
    assign ir_out   = ir_q;
    assign pc_plus1 = pc_plus1_q;
    assign ir_valid = (state_q == ST_HOLD);
    assign adv_err  = adv_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        run;
    logic [31:0] pc_out;
    logic [31:0] imem_instr;
    logic [31:0] ir_out;
    logic        ir_valid;
    logic [31:0] pc_plus1;
    logic        pc_advance;
    logic [1:0]  pc_src;
    logic        br_taken;
    logic        adv_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:31];
    int n_checks;
    int n_errors;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    instr_fetch_unit #(.RESET_PC(32'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .pc_out      (pc_out),
        .imem_instr  (imem_instr),
        .ir_out      (ir_out),
        .ir_valid    (ir_valid),
        .pc_plus1    (pc_plus1),
        .pc_advance  (pc_advance),
        .pc_src      (pc_src),
        .br_taken    (br_taken),
        .adv_err     (adv_err),
        .fetch_count (fetch_count)
    );

    assign imem_instr = mem[pc_out[4:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge in HOLD; ends at the negedge of the following HOLD cycle.
    task automatic adv_fetch(input string tag, input logic [1:0] src, input logic taken,
                             input logic [31:0] exp_pc, input logic [31:0] exp_ir);
        logic [31:0] exp_p1;
        exp_p1     = exp_pc + 32'd1;
        pc_advance = 1'b1;
        pc_src     = src;
        br_taken   = taken;
        @(negedge clk);
        pc_advance = 1'b0;
        check({tag, " fetch pc_out"}, pc_out, exp_pc);
        check({tag, " fetch ir_valid"}, {31'd0, ir_valid}, 32'd0);
        @(negedge clk);
        check({tag, " hold ir_valid"}, {31'd0, ir_valid}, 32'd1);
        check({tag, " hold ir"}, ir_out, exp_ir);
        check({tag, " hold pc_plus1"}, pc_plus1, exp_p1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        run        = 1'b0;
        pc_advance = 1'b0;
        pc_src     = 2'b00;
        br_taken   = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        mem[0]  = 32'hC821_0005;
        mem[1]  = 32'h0000_FFFD;
        mem[2]  = 32'h0800_0006;
        mem[4]  = 32'h0800_0006;
        mem[6]  = 32'h1000_FFFD;
        mem[7]  = 32'h0800_001A;
        mem[21] = 32'h0800_001A;
        mem[26] = 32'h0000_0015;
        mem[31] = 32'h0000_ABCD;

        @(negedge clk);
        check("rst pc_out", pc_out, 32'd0);
        check("rst ir", ir_out, 32'd0);
        check("rst ir_valid", {31'd0, ir_valid}, 32'd0);
        check("rst pc_plus1", pc_plus1, 32'd0);
        check("rst adv_err", {31'd0, adv_err}, 32'd0);
        check("rst fetch_count", fetch_count, 32'd0);

        rst        = 1'b0;
        pc_advance = 1'b1;
        @(negedge clk);
        pc_advance = 1'b0;
        check("idle adv adv_err", {31'd0, adv_err}, 32'd1);
        check("idle adv pc_out", pc_out, 32'd0);
        check("idle adv ir_valid", {31'd0, ir_valid}, 32'd0);

        run = 1'b1;
        @(negedge clk);
        check("first fetch pc_out", pc_out, 32'd0);
        check("first fetch ir_valid", {31'd0, ir_valid}, 32'd0);
        @(negedge clk);
        check("first hold ir", ir_out, 32'hC821_0005);
        check("first hold pc_plus1", pc_plus1, 32'd1);
        check("first hold ir_valid", {31'd0, ir_valid}, 32'd1);

        adv_fetch("seq0", 2'b00, 1'b0, 32'd1, 32'h0000_FFFD);
        adv_fetch("seq1", 2'b00, 1'b0, 32'd2, 32'h0800_0006);
        check("count3", fetch_count, PERF ? 32'd3 : 32'd0);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall ir", ir_out, 32'h0800_0006);
            check("stall pc_out", pc_out, 32'd2);
            check("stall ir_valid", {31'd0, ir_valid}, 32'd1);
            check("stall count", fetch_count, PERF ? 32'd3 : 32'd0);
        end

        adv_fetch("jmp6", 2'b10, 1'b0, 32'd6, 32'h1000_FFFD);
        adv_fetch("br_taken", 2'b01, 1'b1, 32'd4, 32'h0800_0006);
        adv_fetch("jmp6b", 2'b10, 1'b0, 32'd6, 32'h1000_FFFD);
        adv_fetch("br_not_taken", 2'b01, 1'b0, 32'd7, 32'h0800_001A);
        adv_fetch("jmp26", 2'b10, 1'b0, 32'd26, 32'h0000_0015);
        adv_fetch("jmp21", 2'b10, 1'b0, 32'd21, 32'h0800_001A);
        mem[26] = 32'h0400_0000;
        adv_fetch("jmp26b", 2'b10, 1'b0, 32'd26, 32'h0400_0000);
        adv_fetch("jmp0", 2'b10, 1'b0, 32'd0, 32'hC821_0005);
        adv_fetch("reserved_src", 2'b11, 1'b1, 32'd1, 32'h0000_FFFD);
        adv_fetch("br_to_max", 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0000_ABCD);
        adv_fetch("wrap", 2'b00, 1'b0, 32'd0, 32'hC821_0005);

        pc_advance = 1'b1;
        pc_src     = 2'b00;
        run        = 1'b0;
        @(negedge clk);
        pc_advance = 1'b0;
        check("to_idle ir_valid", {31'd0, ir_valid}, 32'd0);
        check("to_idle pc_out", pc_out, 32'd1);
        @(negedge clk);
        check("idle stay ir_valid", {31'd0, ir_valid}, 32'd0);
        check("idle stay ir", ir_out, 32'hC821_0005);
        run = 1'b1;
        @(negedge clk);
        check("refetch pc_out", pc_out, 32'd1);
        check("refetch ir_valid", {31'd0, ir_valid}, 32'd0);
        run = 1'b0;
        @(negedge clk);
        check("run drop ir_valid", {31'd0, ir_valid}, 32'd1);
        check("run drop ir", ir_out, 32'h0000_FFFD);
        check("sticky adv_err", {31'd0, adv_err}, 32'd1);

        rst = 1'b1;
        run = 1'b1;
        pc_advance = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pc_advance = 1'b0;
        check("hold rst pc_out", pc_out, 32'd0);
        check("hold rst ir", ir_out, 32'd0);
        check("hold rst ir_valid", {31'd0, ir_valid}, 32'd0);
        check("hold rst adv_err", {31'd0, adv_err}, 32'd0);
        check("hold rst pc_plus1", pc_plus1, 32'd0);
        check("hold rst count", fetch_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage of the multicycle CPU, sitting directly upstream of the instruction memory. It owns the program counter, drives the word address into instruction memory, latches the returned word into the instruction register (IR), and computes the next PC: sequential, PC-relative branch, or absolute jump. It hands the IR to the decode/controller stage under a valid/advance handshake, so the controller can hold an instruction across any number of execute cycles.

## Interface
- `RESET_PC`, default 0: PC value loaded on reset (word address).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; permits fetching.
- `pc_out`  out  32  word address to instruction memory.
- `imem_instr`  in  32  instruction word from memory (combinational, valid the same cycle as `pc_out`).
- `ir_out`  out  32  latched instruction.
- `ir_valid`  out  1  `ir_out` holds a fetched instruction awaiting retirement.
- `pc_plus1`  out  32  address of the instruction in IR plus 1.
- `pc_advance`  in  1  one-cycle pulse from the controller; retires the current IR.
- `pc_src`  in  2  next-PC select, sampled with `pc_advance`: 00 seq, 01 branch, 10 jump, 11 reserved (treated as seq).
- `br_taken`  in  1  branch condition from the ALU, sampled with `pc_advance`.
- `adv_err`  out  1  sticky; set when `pc_advance` arrives while `ir_valid` = 0.
- `fetch_count`  out  32  number of IR loads (see Configuration).

## Operation
- The state machine has three states: IDLE, FETCH, HOLD.
- **IDLE**
  - `ir_valid` = 0.
  - Go to FETCH when `run` = 1.
- **FETCH** (exactly one cycle)
  - `pc_out` = PC.
  - At the edge: IR ← `imem_instr`, `pc_plus1` ← PC + 1, go to HOLD.
- **HOLD**
  - `ir_valid` = 1; IR and PC are frozen.
  - On `pc_advance`, PC ← next PC. Then go to FETCH if `run` = 1, otherwise go to IDLE.
- **Next PC**
  - seq: `pc_plus1`.
  - branch with `br_taken` = 1: `pc_plus1` + sign-extend(IR[15:0]).
  - branch with `br_taken` = 0: `pc_plus1`.
  - jump: {`pc_plus1`[31:26], IR[25:0]}.
- All PC arithmetic is 32-bit modulo 2^32. Wrap from 0xFFFFFFFF to 0 is legal and silent.
- A `pc_advance` in IDLE or FETCH is ignored and sets `adv_err`. `adv_err` clears only on reset.
- `run` deasserting during FETCH does not abort the fetch; the IR still loads.
- **Reset values:** PC = `RESET_PC`, `pc_out` = `RESET_PC`, IR = 0 (NOOP), `pc_plus1` = 0, `ir_valid` = 0, `adv_err` = 0, `fetch_count` = 0, state = IDLE.
- Reset asserted mid-operation overrides every other input in that cycle.

## Timing
- Fetch latency: 1 cycle from entering FETCH to `ir_valid` = 1.
- `pc_advance` at edge N updates PC at edge N. FETCH occupies cycle N+1 with the new `pc_out`. The new IR is valid from cycle N+2.
- Minimum issue interval is 2 cycles per instruction, when the controller advances in the first HOLD cycle.
- `pc_out` is registered and stable for the whole FETCH cycle.
- `ir_out` and `pc_plus1` change only on the FETCH→HOLD edge.
- `run` is sampled in IDLE, and on the `pc_advance` edge in HOLD.

## Configuration
- `FETCH_PERF_EN` defined:
  - `fetch_count` increments on every FETCH→HOLD edge.
  - Wraps at 2^32; resets to 0.
- Not defined: `fetch_count` is tied to 0 and no counter register is instantiated.

## Structure
- Package `fetch_pkg` holds:
  - the state encoding (IDLE/FETCH/HOLD);
  - the `pc_src` encodings (PC_SEQ, PC_BR, PC_JMP);
  - the opcode-field bit positions [31:26], jump-field [25:0] and immediate-field [15:0] constants.
- Sub-module `next_pc_calc`: combinational next-PC mux and adder.
  - Inputs: `pc_plus1`, IR, `pc_src`, `br_taken`.
  - Output: 32-bit next PC.
- The top level holds the FSM, PC/IR/`pc_plus1` registers, `adv_err` and the optional counter.

## Test plan
- Reset, `run` = 1, memory returns 0x C8210005 at address 0, advance with seq → IR = 0xC8210005 one cycle after FETCH; `pc_out` sequence 0, 1, 2 with `ir_valid` low in each FETCH cycle.
- Branch at PC 6 with IR[15:0] = 0xFFFD, `br_taken` = 1 → next `pc_out` = 4. Same instruction with `br_taken` = 0 → next `pc_out` = 7.
- Jump at PC 26 with IR = 0x04000000 → next `pc_out` = 0. With IR[25:0] = 0x15 → next `pc_out` = 21.
- Controller holds HOLD for 5 cycles before `pc_advance` → IR and PC unchanged throughout; no fetch occurs.
- `pc_advance` pulsed in IDLE → `adv_err` = 1 and PC unchanged. `rst` asserted in HOLD → next cycle PC = 0, IR = 0, `ir_valid` = 0, `adv_err` = 0.
- PC = 0xFFFFFFFF, seq advance → `pc_out` = 0. With `FETCH_PERF_EN`, 3 fetches → `fetch_count` = 3; without it, `fetch_count` = 0.
